// File: rtl/safebox_pkg.sv
// Shared types and helpers for the dial combination checker.
// Dial geometry, FSM/direction encodings and the movement classifier.
package safebox_pkg;

    localparam int POS_W      = 7;
    localparam int DIAL_STEPS = 128;

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_C    = 3'd2,
        S_OPEN = 3'd3,
        S_FAIL = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        DIR_NONE = 2'b00,
        DIR_CW   = 2'b01,
        DIR_CCW  = 2'b10
    } dir_t;

    // Half-turn (64) is ambiguous and reported as DIR_NONE so the caller keeps the old direction.
    function automatic dir_t classify(input logic [POS_W-1:0] delta);
        dir_t d;
        if (delta == 7'd0) begin
            d = DIR_NONE;
        end else if (delta < 7'd64) begin
            d = DIR_CW;
        end else if (delta == 7'd64) begin
            d = DIR_NONE;
        end else begin
            d = DIR_CCW;
        end
        return d;
    endfunction

    function automatic logic [1:0] stage_of(input state_t s);
        logic [1:0] st;
        case (s)
            S_B:     st = 2'd1;
            S_C:     st = 2'd2;
            S_OPEN:  st = 2'd3;
            default: st = 2'd0;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/dial_tracker.sv
// Dial position tracker: captures position, classifies rotation direction and
// emits a single stop pulse once a position has been held for DWELL edges.
module dial_tracker
    import safebox_pkg::*;
#(
    parameter int DWELL = 16,
    parameter int CNT_W = $clog2(DWELL + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [POS_W-1:0] code,
    output logic [POS_W-1:0] pos,
    output dir_t             dir,
    output dir_t             move_dir,
    output logic             move,
    output logic             stop
);

    logic [POS_W-1:0] pos_r;
    logic [CNT_W-1:0] cnt_r;
    dir_t             dir_r;
    logic [POS_W-1:0] delta_s;
    logic             move_s;
    dir_t             move_dir_s;
    logic             stop_s;

    // Movement decode against the captured position; subtraction wraps mod 128.
    always_comb begin
        delta_s    = code - pos_r;
        move_s     = (code != pos_r);
        move_dir_s = classify(delta_s);
        stop_s     = (!move_s) && (cnt_r == CNT_W'(DWELL - 1));
    end

    // Position capture, direction memory and saturating dwell counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_r <= 7'd0;
            cnt_r <= '0;
            dir_r <= DIR_NONE;
        end else if (move_s) begin
            pos_r <= code;
            cnt_r <= '0;
            if (move_dir_s != DIR_NONE) begin
                dir_r <= move_dir_s;
            end else begin
                dir_r <= dir_r;
            end
        end else if (cnt_r != CNT_W'(DWELL)) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign pos      = pos_r;
    assign dir      = dir_r;
    assign move_dir = move_dir_s;
    assign move     = move_s;
    assign stop     = stop_s;

endmodule

// File: rtl/dial_sequencer.sv
// Combination sequencer: CW to A, CCW to B, CW to C opens the vault.
// Consumes the tracker's stop/move events; all outputs are registered.
module dial_sequencer
    import safebox_pkg::*;
#(
    parameter int DWELL = 16
) (
    input  logic       Clock,
    input  logic       nReset,
    input  logic [7:0] vault_code,
    input  logic [6:0] combo_a,
    input  logic [6:0] combo_b,
    input  logic [6:0] combo_c,
    input  logic       lock,
    output logic       unlocked,
    output logic [1:0] stage,
    output logic       fail,
    output logic [1:0] dir
);

    localparam int CNT_W = $clog2(DWELL + 1);

    logic [POS_W-1:0] pos_s;
    dir_t             dir_s;
    dir_t             move_dir_s;
    logic             move_s;
    logic             stop_s;
    logic             code_unused_s;

    state_t           state_r;
    state_t           state_next_s;
    logic             unlocked_r;
    logic [1:0]       stage_r;
    logic             fail_r;

    // Bit 7 of the look-up table output carries no position information.
    assign code_unused_s = vault_code[7];

    dial_tracker #(
        .DWELL (DWELL),
        .CNT_W (CNT_W)
    ) u_tracker (
        .clk      (Clock),
        .rst_n    (nReset),
        .code     (vault_code[6:0]),
        .pos      (pos_s),
        .dir      (dir_s),
        .move_dir (move_dir_s),
        .move     (move_s),
        .stop     (stop_s)
    );

    // Next-state logic; lock overrides any simultaneous stop or move.
    always_comb begin
        state_next_s = state_r;
        if (lock) begin
            state_next_s = S_A;
        end else begin
            case (state_r)
                S_A: begin
                    if (stop_s && (dir_s == DIR_CW) && (pos_s == combo_a)) begin
                        state_next_s = S_B;
                    end else begin
                        state_next_s = S_A;
                    end
                end
                S_B: begin
                    if (move_s && (move_dir_s == DIR_CW)) begin
                        state_next_s = S_FAIL;
                    end else if (stop_s && (dir_s == DIR_CCW) && (pos_s == combo_b)) begin
                        state_next_s = S_C;
                    end else begin
                        state_next_s = S_B;
                    end
                end
                S_C: begin
                    if (move_s && (move_dir_s == DIR_CCW)) begin
                        state_next_s = S_FAIL;
                    end else if (stop_s && (dir_s == DIR_CW) && (pos_s == combo_c)) begin
                        state_next_s = S_OPEN;
                    end else begin
                        state_next_s = S_C;
                    end
                end
                S_OPEN: begin
                    state_next_s = S_OPEN;
                end
                S_FAIL: begin
                    if (stop_s && (pos_s == 7'd0)) begin
                        state_next_s = S_A;
                    end else begin
                        state_next_s = S_FAIL;
                    end
                end
                default: begin
                    state_next_s = S_A;
                end
            endcase
        end
    end

    // State register with outputs decoded from the next state so they align with it.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_r    <= S_A;
            unlocked_r <= 1'b0;
            stage_r    <= 2'd0;
            fail_r     <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            unlocked_r <= (state_next_s == S_OPEN);
            stage_r    <= stage_of(state_next_s);
            fail_r     <= (state_next_s == S_FAIL);
        end
    end

    assign unlocked = unlocked_r;
    assign stage    = stage_r;
    assign fail     = fail_r;
    assign dir      = dir_s;

endmodule

// File: tb/tb_dial_sequencer.sv
// Bench for dial_sequencer (DWELL=4, A=10, B=50, C=100): expected outputs are
// queued as each input is driven and compared one edge later.
module tb_dial_sequencer;

    logic       Clock;
    logic       nReset;
    logic [7:0] vault_code;
    logic [6:0] combo_a, combo_b, combo_c;
    logic       lock;
    logic       unlocked;
    logic [1:0] stage;
    logic       fail;
    logic [1:0] dir;

    localparam logic [1:0] CW  = 2'b01;
    localparam logic [1:0] CCW = 2'b10;

    typedef struct {
        logic [6:0] code;
        logic       lk;
        logic [1:0] st;
        logic       fl;
        logic       un;
        logic [1:0] dr;
    } vec_t;

    typedef struct {
        string      name;
        logic [1:0] st;
        logic       fl;
        logic       un;
        logic [1:0] dr;
    } exp_t;

    exp_t sb_q[$];
    exp_t cur;
    vec_t tbl[18];
    int   n_tests = 0;
    int   n_fail  = 0;

    dial_sequencer #(.DWELL(4)) dut (
        .Clock      (Clock),
        .nReset     (nReset),
        .vault_code (vault_code),
        .combo_a    (combo_a),
        .combo_b    (combo_b),
        .combo_c    (combo_c),
        .lock       (lock),
        .unlocked   (unlocked),
        .stage      (stage),
        .fail       (fail),
        .dir        (dir)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Drive one input vector (bit 7 randomised, it must be ignored) and queue the expectation.
    task automatic step(input string nm, input logic [6:0] code, input logic lk,
                        input logic [1:0] st, input logic fl, input logic un, input logic [1:0] dr);
        exp_t e;
        logic b7;
        @(negedge Clock);
        b7         = 1'($urandom_range(1, 0));
        vault_code = {b7, code};
        lock       = lk;
        e.name = nm; e.st = st; e.fl = fl; e.un = un; e.dr = dr;
        sb_q.push_back(e);
    endtask

    task automatic walk(input string nm, input logic [6:0] from, input logic [6:0] to,
                        input logic cw, input logic [1:0] st, input logic un);
        logic [6:0] p;
        p = from;
        do begin
            p = cw ? p + 7'd1 : p - 7'd1;
            step(nm, p, 1'b0, st, 1'b0, un, cw ? CW : CCW);
        end while (p != to);
    endtask

    task automatic hold(input string nm, input logic [6:0] code, input int n,
                        input logic [1:0] st, input logic un, input logic [1:0] dr);
        for (int i = 0; i < n; i++) begin
            step(nm, code, 1'b0, st, 1'b0, un, dr);
        end
    endtask

    task automatic drain();
        repeat (2) @(posedge Clock);
        #2;
        check("scoreboard drain", sb_q.size(), 0);
    endtask

    // Scoreboard consumer: compare one queued expectation just after each rising edge.
    always @(posedge Clock) begin
        #1;
        if (sb_q.size() > 0) begin
            cur = sb_q.pop_front();
            check({cur.name, " stage"},    int'(stage),    int'(cur.st));
            check({cur.name, " fail"},     int'(fail),     int'(cur.fl));
            check({cur.name, " unlocked"}, int'(unlocked), int'(cur.un));
            check({cur.name, " dir"},      int'(dir),      int'(cur.dr));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // S_B fail path (ambiguous jump, CCW, CW fail, recovery at 0), then wrap classification
        tbl[0]  = '{7'd74,  1'b0, 2'd1, 1'b0, 1'b0, CW};
        tbl[1]  = '{7'd30,  1'b0, 2'd1, 1'b0, 1'b0, CCW};
        tbl[2]  = '{7'd31,  1'b0, 2'd0, 1'b1, 1'b0, CW};
        tbl[3]  = '{7'd0,   1'b0, 2'd0, 1'b1, 1'b0, CCW};
        tbl[4]  = '{7'd0,   1'b0, 2'd0, 1'b1, 1'b0, CCW};
        tbl[5]  = '{7'd0,   1'b0, 2'd0, 1'b1, 1'b0, CCW};
        tbl[6]  = '{7'd0,   1'b0, 2'd0, 1'b1, 1'b0, CCW};
        tbl[7]  = '{7'd0,   1'b0, 2'd0, 1'b0, 1'b0, CCW};
        tbl[8]  = '{7'd126, 1'b0, 2'd0, 1'b0, 1'b0, CCW};
        tbl[9]  = '{7'd127, 1'b0, 2'd0, 1'b0, 1'b0, CW};
        tbl[10] = '{7'd0,   1'b0, 2'd0, 1'b0, 1'b0, CW};
        tbl[11] = '{7'd1,   1'b0, 2'd0, 1'b0, 1'b0, CW};
        tbl[12] = '{7'd0,   1'b0, 2'd0, 1'b0, 1'b0, CCW};
        tbl[13] = '{7'd127, 1'b0, 2'd0, 1'b0, 1'b0, CCW};
        tbl[14] = '{7'd0,   1'b0, 2'd0, 1'b0, 1'b0, CW};
        tbl[15] = '{7'd64,  1'b0, 2'd0, 1'b0, 1'b0, CW};
        tbl[16] = '{7'd63,  1'b0, 2'd0, 1'b0, 1'b0, CCW};
        tbl[17] = '{7'd127, 1'b0, 2'd0, 1'b0, 1'b0, CCW};

        nReset     = 1'b1;
        vault_code = 8'd0;
        lock       = 1'b0;
        combo_a    = 7'd10;
        combo_b    = 7'd50;
        combo_c    = 7'd100;
        #1 nReset  = 1'b0;
        #1;
        check("reset stage",    int'(stage),    0);
        check("reset fail",     int'(fail),     0);
        check("reset unlocked", int'(unlocked), 0);
        check("reset dir",      int'(dir),      0);
        @(negedge Clock);
        nReset = 1'b1;

        // Full opening sequence; stage must change on the 4th hold edge, not the 3rd
        walk("cw to A", 7'd0, 7'd10, 1'b1, 2'd0, 1'b0);
        hold("dwell A", 7'd10, 3, 2'd0, 1'b0, CW);
        step("stop A", 7'd10, 1'b0, 2'd1, 1'b0, 1'b0, CW);
        walk("ccw to B", 7'd10, 7'd50, 1'b0, 2'd1, 1'b0);
        hold("dwell B", 7'd50, 3, 2'd1, 1'b0, CCW);
        step("stop B", 7'd50, 1'b0, 2'd2, 1'b0, 1'b0, CCW);
        walk("cw to C", 7'd50, 7'd100, 1'b1, 2'd2, 1'b0);
        hold("dwell C", 7'd100, 3, 2'd2, 1'b0, CW);
        step("open", 7'd100, 1'b0, 2'd3, 1'b0, 1'b1, CW);

        // Open ignores motion; lock coincident with a stop event wins
        step("open move", 7'd101, 1'b0, 2'd3, 1'b0, 1'b1, CW);
        hold("open dwell", 7'd101, 3, 2'd3, 1'b1, CW);
        step("lock on stop", 7'd101, 1'b1, 2'd0, 1'b0, 1'b0, CW);

        walk("cw to A again", 7'd101, 7'd10, 1'b1, 2'd0, 1'b0);
        hold("dwell A2", 7'd10, 3, 2'd0, 1'b0, CW);
        step("stop A2", 7'd10, 1'b0, 2'd1, 1'b0, 1'b0, CW);
        for (int i = 0; i < 18; i++) begin
            step($sformatf("tbl%0d", i), tbl[i].code, tbl[i].lk, tbl[i].st,
                 tbl[i].fl, tbl[i].un, tbl[i].dr);
        end

        // Short dwell then move away; arriving CCW onto A never counts
        walk("cw to 10", 7'd127, 7'd10, 1'b1, 2'd0, 1'b0);
        hold("short dwell", 7'd10, 3, 2'd0, 1'b0, CW);
        step("move 11", 7'd11, 1'b0, 2'd0, 1'b0, 1'b0, CW);
        step("back 10", 7'd10, 1'b0, 2'd0, 1'b0, 1'b0, CCW);
        hold("ccw dwell", 7'd10, 4, 2'd0, 1'b0, CCW);

        // Reach S_C, then async reset mid-cycle
        step("to 9", 7'd9, 1'b0, 2'd0, 1'b0, 1'b0, CCW);
        step("to 10", 7'd10, 1'b0, 2'd0, 1'b0, 1'b0, CW);
        hold("dwell A3", 7'd10, 3, 2'd0, 1'b0, CW);
        step("stop A3", 7'd10, 1'b0, 2'd1, 1'b0, 1'b0, CW);
        walk("ccw to B3", 7'd10, 7'd50, 1'b0, 2'd1, 1'b0);
        hold("dwell B3", 7'd50, 3, 2'd1, 1'b0, CCW);
        step("stop B3", 7'd50, 1'b0, 2'd2, 1'b0, 1'b0, CCW);
        @(posedge Clock);
        #2;
        nReset = 1'b0;
        #1;
        check("async rst stage",    int'(stage),    0);
        check("async rst fail",     int'(fail),     0);
        check("async rst unlocked", int'(unlocked), 0);
        check("async rst dir",      int'(dir),      0);
        check("async rst queue",    sb_q.size(),    0);
        @(negedge Clock);
        nReset = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dial_sequencer.md
Name: dial_sequencer

Overview:
- Sequential combination checker directly downstream of the encoder look-up table.
- Consumes the decoded dial position (0..127) every clock and tracks rotation direction and dwell.
- Enforces the safe sequence: CW to A, CCW to B, CW to C. It drives the vault unlock output and status to the display/actuator logic.

Parameters:
DWELL, 16, clock cycles a position must stay unchanged to count as "stopped on" a number (>=2)
CNT_W, $clog2(DWELL+1), dwell counter width (derived, not overridden)

Ports:
Clock  input  1  system clock, rising edge
nReset  input  1  asynchronous active-low reset
vault_code  input  8  decoded dial position from the look-up table; bits [6:0] used, bit 7 ignored; synchronous to Clock
combo_a  input  7  first combination number (CW)
combo_b  input  7  second combination number (CCW)
combo_c  input  7  third combination number (CW)
lock  input  1  synchronous relock/abort request, level sampled each edge
unlocked  output  1  high while vault is open
stage  output  2  digits accepted so far: 0,1,2,3 (3 = open)
fail  output  1  high while sequence is in failed state
dir  output  2  last movement direction: 00 none, 01 CW, 10 CCW

Behaviour:
- Reset (async, nReset=0): pos_q=0, dwell count=0, dir=00, state=S_A, unlocked=0, stage=0, fail=0. Release is synchronous to the next edge.
- Tracker, each edge:
  - move = (vault_code[6:0] != pos_q).
  - delta = (vault_code[6:0] - pos_q) mod 128.
  - delta 1..63 -> CW; 65..127 -> CCW; 64 -> ambiguous: pos_q updates, dir unchanged, counts as a move.
  - On move: pos_q <= new value, count <= 0, dir updated.
  - No move: count increments, saturating at DWELL.
  - stop event = !move && count==DWELL-1. It fires exactly once per rest: a pulse on the edge where count reaches DWELL.
- Latency: the FSM acts on the DWELL-th edge after the edge that captured the position. A move during dwell restarts the count.
- Wrap-around: 127->0 is CW (delta 1); 0->127 is CCW (delta 127).
- FSM states (all outputs registered):
  - S_A: stop event with dir=CW and pos_q==combo_a -> S_B. CCW moves and other stops are ignored, so the user may keep turning.
  - S_B: stop with dir=CCW and pos_q==combo_b -> S_C. Any CW move -> S_FAIL. Other stops are ignored.
  - S_C: stop with dir=CW and pos_q==combo_c -> S_OPEN. Any CCW move -> S_FAIL.
  - S_OPEN: unlocked=1, stage=3. Dial motion is ignored. Leaves only on lock.
  - S_FAIL: fail=1, stage=0. Returns to S_A on a stop event at position 0 (any dir) or on lock.
- stage = 0 in S_A/S_FAIL, 1 in S_B, 2 in S_C, 3 in S_OPEN.
- lock=1: next state S_A from any state, regardless of simultaneous stop/move; tracker keeps running.
- combo_* are sampled only at the stop-event edge. Changing them mid-sequence takes effect at the next comparison.
- Equal combination numbers (e.g. A==B) are legal. A direction reversal is still required between digits.
- Position 0 doubles as the look-up table's default for illegal patterns; it is treated as a genuine position.

Decomposition:
- safebox_pkg: state enum (S_A, S_B, S_C, S_OPEN, S_FAIL), dir enum (DIR_NONE, DIR_CW, DIR_CCW), POS_W=7, DIAL_STEPS=128.
- One sub-module, dial_tracker:
  - Contains pos_q, delta/direction decode, dwell counter and stop pulse.
  - Outputs pos, dir, move, stop.
- dial_sequencer instantiates dial_tracker and holds the FSM and output registers.

Test Plan (DWELL=4, A=10, B=50, C=100):
- Reset mid-sequence (in S_C): drop nReset asynchronously -> unlocked=0, stage=0, fail=0, dir=00 immediately, before any clock edge.
- Step CW 0..10 one per cycle, hold 10 for 4 edges -> stage=1 on the 4th edge after capture, not the 3rd. Then step CCW 10..50 (wrapping 10->0->127..50), hold -> stage=2. Then step CW 50..100, hold -> stage=3 and unlocked=1.
- In S_B, single CW step 30->31 -> fail=1, stage=0 next edge. Hold 0 for 4 edges -> fail=0, state S_A.
- Wrap direction: 126->127->0->1 classed CW (dir=01); 1->0->127 classed CCW (dir=10). Jump 0->64 leaves dir unchanged.
- Hold 10 for only 3 edges, then move to 11 -> no stage change. Dwell-restart check: hold 10 for 4 edges after arriving CCW -> stays stage 0.
- Open, then assert lock same edge as a stop event -> state S_A, unlocked=0, stage=0. Lock wins.
